pe_regfile_mc: RTL and testbench

Parametrised multi-channel register file for a CGRA processing element; successor to the fixed 64x32, four-channel PE register block. Captures data from NCH neighbour/bus input channels, accepts FU writeback, feeds two FU operand ports with per-port channel bypass, and drives a registered, valid-tagged send to any subset of output channels. Adds per-register valid bits, an occupancy counter and a sticky select-error flag, so configuration faults are detectable.

---
 rtl/pe_rf_pkg.sv | 34 +++
 rtl/pe_regfile_mc_if.sv | 48 ++++
 rtl/pe_rf_onehot_mux.sv | 34 +++
 rtl/pe_regfile_mc.sv | 104 ++++++++++
 tb/tb_pe_regfile_mc.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_rf_pkg.sv
// Shared constants and helpers for the multi-channel PE register file.
package pe_rf_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 64;
  localparam int DEF_NCH  = 4;

  // Widest select vector onehot_idx can decode; narrower selects are zero-extended.
  localparam int MAX_NCH = 32;
  localparam int IDX_W   = $clog2(MAX_NCH);

  typedef struct packed {
    logic             is_onehot;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  // Decodes a select vector: index of the set bit, and whether exactly one bit is set.
  function automatic onehot_t onehot_idx(input logic [MAX_NCH-1:0] sel);
    onehot_t r;
    int      n;
    r.idx       = '0;
    r.is_onehot = 1'b0;
    n           = 0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (sel[i]) begin
        n++;
        r.idx = IDX_W'(i);
      end
    end
    r.is_onehot = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/pe_regfile_mc_if.sv
// Channel, FU and control bundle of the PE register file.
interface pe_regfile_mc_if
  import pe_rf_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NCH  = DEF_NCH
) ();
  localparam int AW = $clog2(NREG);

  logic [NCH*DW-1:0] ch_in;
  logic [NCH-1:0]    ch_in_vld;
  logic [NCH-1:0]    in_sel;
  logic [AW-1:0]     put_in_addr;
  logic              ld;
  logic              ld_write;
  logic [DW-1:0]     fu_res;
  logic              write_back;
  logic [AW-1:0]     put_out_addr;
  logic [NCH-1:0]    rd_sel1;
  logic [NCH-1:0]    rd_sel2;
  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic [DW-1:0]     rd_data1;
  logic [DW-1:0]     rd_data2;
  logic              rd_ok;
  logic [AW-1:0]     send_addr;
  logic [NCH-1:0]    send_mask;
  logic [NCH*DW-1:0] ch_out;
  logic [NCH-1:0]    ch_out_vld;
  logic              clr_all;
  logic [AW:0]       vld_cnt;
  logic              sel_err;

  modport master (
    output ch_in, ch_in_vld, in_sel, put_in_addr, ld, ld_write, fu_res, write_back,
           put_out_addr, rd_sel1, rd_sel2, rd_addr1, rd_addr2, send_addr, send_mask,
           clr_all,
    input  rd_data1, rd_data2, rd_ok, ch_out, ch_out_vld, vld_cnt, sel_err
  );

  modport slave (
    input  ch_in, ch_in_vld, in_sel, put_in_addr, ld, ld_write, fu_res, write_back,
           put_out_addr, rd_sel1, rd_sel2, rd_addr1, rd_addr2, send_addr, send_mask,
           clr_all,
    output rd_data1, rd_data2, rd_ok, ch_out, ch_out_vld, vld_cnt, sel_err
  );
endinterface

// File: rtl/pe_rf_onehot_mux.sv
// NCH-way one-hot channel mux: data/valid of the selected channel, plus a flag
// for a nonzero select that is not one-hot (which yields zero data, valid low).
module pe_rf_onehot_mux
  import pe_rf_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH*DW-1:0] data,
  input  logic [NCH-1:0]    vld,
  input  logic [NCH-1:0]    sel,
  output logic [DW-1:0]     dout,
  output logic              vout,
  output logic              hit,
  output logic              err
);
  onehot_t oh;
  assign oh = onehot_idx(MAX_NCH'(sel));

  // Route the selected channel; anything but a clean one-hot select gives zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dout = '0;
    vout = 1'b0;
    hit  = oh.is_onehot;
    err  = (sel != '0) && !oh.is_onehot;
    for (int k = 0; k < NCH; k++) begin
      if (oh.is_onehot && int'(oh.idx) == k) begin
        dout = data[k*DW +: DW];
        vout = vld[k];
      end
    end
  end
endmodule

// File: rtl/pe_regfile_mc.sv
// Multi-channel PE register file: channel capture, FU writeback, two bypassable
// operand ports, registered masked send, valid bits, occupancy count, select-error flag.
module pe_regfile_mc
  import pe_rf_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NCH  = DEF_NCH,
  localparam int AW  = $clog2(NREG)
) (
  input logic              CLK,
  input logic              RST,
  pe_regfile_mc_if.slave   bus
);
  logic [DW-1:0]     mem [NREG];
  logic [NREG-1:0]   valid;
  logic [AW:0]       cnt;
  logic              err_q;
  logic [NCH*DW-1:0] ch_out_q;
  logic [NCH-1:0]    ch_vld_q;

  logic [DW-1:0] cap_data, op1_data, op2_data;
  logic          cap_vld, op1_vld, op2_vld;
  logic          cap_hit, op1_hit, op2_hit;
  logic          cap_err, op1_err, op2_err;

  pe_rf_onehot_mux #(.DW(DW), .NCH(NCH)) u_cap_mux (
    .data(bus.ch_in), .vld(bus.ch_in_vld), .sel(bus.in_sel),
    .dout(cap_data), .vout(cap_vld), .hit(cap_hit), .err(cap_err));
  pe_rf_onehot_mux #(.DW(DW), .NCH(NCH)) u_op1_mux (
    .data(bus.ch_in), .vld(bus.ch_in_vld), .sel(bus.rd_sel1),
    .dout(op1_data), .vout(op1_vld), .hit(op1_hit), .err(op1_err));
  pe_rf_onehot_mux #(.DW(DW), .NCH(NCH)) u_op2_mux (
    .data(bus.ch_in), .vld(bus.ch_in_vld), .sel(bus.rd_sel2),
    .dout(op2_data), .vout(op2_vld), .hit(op2_hit), .err(op2_err));

  logic          cap_en, same_addr, wb_new, cap_new;
  logic [AW:0]   n_new;

  assign cap_en    = cap_hit && cap_vld && (!bus.ld || bus.ld_write);
  assign same_addr = bus.write_back && cap_en && (bus.put_in_addr == bus.put_out_addr);
  assign wb_new    = bus.write_back && !valid[bus.put_out_addr];
  assign cap_new   = cap_en && !valid[bus.put_in_addr] && !same_addr;
  assign n_new     = (AW+1)'(wb_new) + (AW+1)'(cap_new);

  // Register data; writeback is issued last so it wins an address collision.
  // NOTE: the data array has no reset -- the valid bits hide stale contents.
  always_ff @(posedge CLK) begin
    if (!RST && !bus.clr_all) begin
      if (cap_en)         mem[bus.put_in_addr]  <= cap_data;
      if (bus.write_back) mem[bus.put_out_addr] <= bus.fu_res;
    end
  end

  // Valid bits, occupancy count and sticky select error; clr_all drops same-cycle writes.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    if (RST) begin
      valid <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (cap_err || op1_err || op2_err) err_q <= 1'b1;
      if (bus.clr_all) begin
        valid <= '0;
        cnt   <= '0;
      end else begin
        if (cap_en)         valid[bus.put_in_addr]  <= 1'b1;
        if (bus.write_back) valid[bus.put_out_addr] <= 1'b1;
        cnt <= cnt + n_new;
      end
    end
  end

  // Registered send of one register to the masked subset of output channels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_out_q <= '0;
      ch_vld_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        ch_out_q[k*DW +: DW] <= bus.send_mask[k] ? mem[bus.send_addr] : '0;
        ch_vld_q[k]          <= bus.send_mask[k] && valid[bus.send_addr];
      end
    end
  end

  // Operand ports: a one-hot or faulty select uses the channel mux, a zero select reads the file.
  logic [DW-1:0] rf1, rf2;
  assign rf1 = valid[bus.rd_addr1] ? mem[bus.rd_addr1] : '0;
  assign rf2 = valid[bus.rd_addr2] ? mem[bus.rd_addr2] : '0;

  logic v1, v2;
  assign bus.rd_data1 = (op1_hit || op1_err) ? op1_data : rf1;
  assign bus.rd_data2 = (op2_hit || op2_err) ? op2_data : rf2;
  assign v1           = (op1_hit || op1_err) ? op1_vld : valid[bus.rd_addr1];
  assign v2           = (op2_hit || op2_err) ? op2_vld : valid[bus.rd_addr2];
  assign bus.rd_ok    = v1 && v2;

  assign bus.ch_out     = ch_out_q;
  assign bus.ch_out_vld = ch_vld_q;
  assign bus.vld_cnt    = cnt;
  assign bus.sel_err    = err_q;
endmodule

// File: tb/tb_pe_regfile_mc.sv
// Directed bench for pe_regfile_mc: stimulus pushes expected values tagged with the
// cycle they must appear; a negedge monitor pops and compares them.
module tb_pe_regfile_mc;
  localparam int DW = 32, NREG = 64, NCH = 4, AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_regfile_mc_if #(.DW(DW), .NREG(NREG), .NCH(NCH)) bus ();
  pe_regfile_mc #(.DW(DW), .NREG(NREG), .NCH(NCH)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef enum {F_RD1, F_RD2, F_RDOK, F_CNT, F_ERR, F_CHOUT, F_CHVLD} fld_e;
  typedef struct {
    int unsigned   cyc;
    fld_e          f;
    logic [127:0]  val;
    string         name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] actual(input fld_e f);
    case (f)
      F_RD1:   return 128'(bus.rd_data1);
      F_RD2:   return 128'(bus.rd_data2);
      F_RDOK:  return 128'(bus.rd_ok);
      F_CNT:   return 128'(bus.vld_cnt);
      F_ERR:   return 128'(bus.sel_err);
      F_CHOUT: return 128'(bus.ch_out);
      default: return 128'(bus.ch_out_vld);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) check(sb[i].name, actual(sb[i].f), sb[i].val);
      else if (sb[i].cyc < cyc) check({sb[i].name, "_overdue"}, 128'd1, 128'd0);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic expect_at(input fld_e f, input logic [127:0] v, input int dly, input string n);
    exp_t e;
    e.cyc = cyc + dly; e.f = f; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ch_in = '0;        bus.ch_in_vld = '0;   bus.in_sel = '0;
    bus.put_in_addr = '0;  bus.ld = 1'b0;        bus.ld_write = 1'b0;
    bus.fu_res = '0;       bus.write_back = 1'b0; bus.put_out_addr = '0;
    bus.rd_sel1 = '0;      bus.rd_sel2 = '0;     bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;     bus.send_addr = '0;   bus.send_mask = '0;
    bus.clr_all = 1'b0;
  endtask

  task automatic capture(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] a);
    bus.ch_in[ch*DW +: DW] = d;
    bus.ch_in_vld[ch]      = 1'b1;
    bus.in_sel             = '0;
    bus.in_sel[ch]         = 1'b1;
    bus.put_in_addr        = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    step(); step();
    rst = 1'b0;
    // Reset state.
    expect_at(F_CNT,   0, 0, "rst_cnt");
    expect_at(F_ERR,   0, 0, "rst_err");
    expect_at(F_CHOUT, 0, 0, "rst_chout");
    expect_at(F_CHVLD, 0, 0, "rst_chvld");
    expect_at(F_RD1,   0, 0, "rst_rd1");
    expect_at(F_RDOK,  0, 0, "rst_rdok");

    // Capture channel 2 into reg 5.
    step(); idle();
    capture(2, 32'hA5A5_0001, 6'd5);
    expect_at(F_CNT, 0, 0, "cap5_cnt_before");
    step(); idle();
    bus.rd_addr1 = 6'd5; bus.rd_addr2 = 6'd5;
    expect_at(F_RD1,  32'hA5A5_0001, 0, "cap5_rd1");
    expect_at(F_RD2,  32'hA5A5_0001, 0, "cap5_rd2");
    expect_at(F_RDOK, 1, 0, "cap5_rdok");
    expect_at(F_CNT,  1, 0, "cap5_cnt");

    // Capture and writeback collide on reg 7: writeback wins, counted once.
    step(); idle();
    capture(0, 32'hDEAD_0007, 6'd7);
    bus.write_back = 1'b1; bus.put_out_addr = 6'd7; bus.fu_res = 32'h1234;
    step(); idle();
    bus.rd_addr1 = 6'd7;
    expect_at(F_RD1, 32'h1234, 0, "collide_rd1");
    expect_at(F_CNT, 2, 0, "collide_cnt");

    // Load gating: ld=1, ld_write=0 blocks capture.
    step(); idle();
    capture(1, 32'h1111_0009, 6'd9);
    bus.ld = 1'b1;
    // Next cycle: reg 9 still invalid; capture again with ld_write=1 (same-cycle read stays old).
    step(); idle();
    bus.rd_addr1 = 6'd9; bus.rd_addr2 = 6'd5;
    capture(1, 32'h1111_0009, 6'd9);
    bus.ld = 1'b1; bus.ld_write = 1'b1;
    expect_at(F_RD1,  0, 0, "ldgate_rd1");
    expect_at(F_RDOK, 0, 0, "ldgate_rdok");
    expect_at(F_CNT,  2, 0, "ldgate_cnt");
    step(); idle();
    bus.rd_addr1 = 6'd9;
    expect_at(F_RD1, 32'h1111_0009, 0, "ldwrite_rd1");
    expect_at(F_CNT, 3, 0, "ldwrite_cnt");

    // Send reg 5 to channels 0 and 3.
    step(); idle();
    bus.send_addr = 6'd5; bus.send_mask = 4'b1001;
    expect_at(F_CHOUT, {32'hA5A5_0001, 64'h0, 32'hA5A5_0001}, 1, "send5_chout");
    expect_at(F_CHVLD, 4'b1001, 1, "send5_chvld");
    step(); idle();
    bus.send_addr = 6'd20; bus.send_mask = 4'b0110;
    expect_at(F_CHVLD, 4'b0000, 1, "send_inv_chvld");

    // Non-one-hot capture select: no write, sticky error.
    step(); idle();
    bus.ch_in = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    bus.ch_in_vld = 4'b1111; bus.in_sel = 4'b0110; bus.put_in_addr = 6'd10;
    expect_at(F_ERR, 0, 0, "selerr_before");
    expect_at(F_ERR, 1, 1, "selerr_set");
    step(); idle();
    bus.ch_in = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    bus.ch_in_vld = 4'b0111; bus.rd_addr1 = 6'd10;
    expect_at(F_RD1, 0, 0, "selerr_nowrite_rd1");
    expect_at(F_CNT, 3, 0, "selerr_nowrite_cnt");
    // Faulty operand select.
    step();
    bus.rd_sel1 = 4'b0011; bus.rd_addr2 = 6'd5;
    expect_at(F_RD1,  0, 0, "opsel_bad_rd1");
    expect_at(F_RDOK, 0, 0, "opsel_bad_rdok");
    // Clean bypass, then bypass of an invalid channel.
    step();
    bus.rd_sel1 = 4'b0100;
    expect_at(F_RD1,  32'h3333_0003, 0, "bypass_rd1");
    expect_at(F_RDOK, 1, 0, "bypass_rdok");
    step();
    bus.rd_sel2 = 4'b1000;
    expect_at(F_RD2,  32'h4444_0004, 0, "bypass_inv_rd2");
    expect_at(F_RDOK, 0, 0, "bypass_inv_rdok");

    // Fill: writeback even addresses, capture odd ones (5, 7, 9 already valid).
    for (int i = 0; i < 32; i++) begin
      step(); idle();
      bus.write_back = 1'b1; bus.put_out_addr = AW'(2*i); bus.fu_res = 32'h100 + i;
      capture(0, 32'hC000_0000 + 2*i + 1, AW'(2*i + 1));
      if (i == 0) expect_at(F_CNT, 5, 1, "fill_cnt_first");
      if (i == 2) expect_at(F_CNT, 8, 1, "fill_cnt_dup");
      if (i == 16) expect_at(F_ERR, 1, 0, "selerr_sticky");
    end
    step(); idle();
    bus.rd_addr1 = 6'd7; bus.rd_addr2 = 6'd6;
    expect_at(F_CNT, NREG, 0, "fill_cnt_full");
    expect_at(F_RD1, 32'hC000_0007, 0, "fill_rd7");
    expect_at(F_RD2, 32'h103, 0, "fill_rd6");

    // clr_all beats a concurrent writeback.
    step(); idle();
    bus.clr_all = 1'b1; bus.write_back = 1'b1; bus.put_out_addr = 6'd3; bus.fu_res = 32'hBAD;
    expect_at(F_CNT, 0, 1, "clr_cnt");
    step(); idle();
    bus.rd_addr1 = 6'd3; bus.rd_addr2 = 6'd3;
    expect_at(F_RD1,  0, 0, "clr_rd1");
    expect_at(F_RDOK, 0, 0, "clr_rdok");

    // Reset mid-operation drops the pending write and clears the sticky error.
    step(); idle();
    bus.write_back = 1'b1; bus.put_out_addr = 6'd4; bus.fu_res = 32'h4;
    bus.send_addr = 6'd4; bus.send_mask = 4'b1111;
    rst = 1'b1;
    expect_at(F_ERR, 1, 0, "err_before_rst");
    step(); idle();
    rst = 1'b0;
    bus.rd_addr1 = 6'd4;
    expect_at(F_CNT,   0, 0, "midrst_cnt");
    expect_at(F_ERR,   0, 0, "midrst_err");
    expect_at(F_CHVLD, 0, 0, "midrst_chvld");
    expect_at(F_RD1,   0, 0, "midrst_rd1");

    step(); step(); step();
    if (sb.size() != 0) check("scoreboard_drain", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
